atc_lookup_ctrl: RTL and testbench
==================================

Name: atc_lookup_ctrl

Overview:
Sequencer for the ATC tag CAM in the MC68851 PMMU. It owns the CAM's pattern, write-enable and write-address inputs.
- Accepts translation lookups from the CPU-side interface and reports hit or miss.
- On a miss it requests a table walk, then fills the returned tag into a round-robin victim slot.
- It flushes the whole CAM after reset and on PFLUSHA-style request. The CAM itself is an external instance.

Parameters:
TAG_W, 24, tag width (function code + logical page number).
DEPTH, 32, CAM entries; power of two, ≥2.
IDX_W, $clog2(DEPTH), entry index width (derived, localparam).

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_valid_i  in  1  lookup request valid
req_ready_o  out  1  controller can accept lookup
req_tag_i  in  TAG_W  lookup tag
resp_valid_o  out  1  response valid
resp_ready_i  in  1  response consumed
resp_hit_o  out  1  1 = found in CAM, 0 = filled after walk
resp_fault_o  out  1  walk reported fault
resp_idx_o  out  IDX_W  CAM entry index hit or filled
walk_req_o  out  1  table-walk request, level
walk_tag_o  out  TAG_W  tag to walk
walk_done_i  in  1  walk complete, 1-cycle pulse
walk_fault_i  in  1  qualifies walk_done_i
flush_i  in  1  flush request, 1-cycle pulse
flush_busy_o  out  1  flush sequence in progress
cam_pattern_o  out  TAG_W+1  {valid, tag} to CAM
cam_we_o  out  1  CAM write enable
cam_wraddr_o  out  IDX_W  CAM write address
cam_found_i  in  1  CAM match-valid (combinational from cam_pattern_o)
cam_match_i  in  IDX_W  CAM encoded match index

Behaviour:
- Reset values: every output is 0. State is FLUSH, flush counter is 0, victim pointer is 0, flush_pending is 0.
- States: FLUSH, IDLE, LOOKUP, WALK, FILL, RESP.
- Pattern encoding: bit TAG_W is the valid bit. Lookups and fills always drive valid=1. Flush writes all-zero, so flushed entries can never match a lookup.
- FLUSH:
  - cam_we_o=1, cam_wraddr_o=counter, cam_pattern_o=0, flush_busy_o=1.
  - The counter increments 0..DEPTH-1, one entry per cycle, for exactly DEPTH cycles, then goes to IDLE.
  - The victim pointer is cleared to 0.
- IDLE:
  - req_ready_o=1. On req_valid_i&req_ready_o, latch tag_q and go to LOOKUP.
  - If flush_pending or flush_i is set, go to FLUSH instead with req_ready_o=0. Flush has priority over a simultaneous request.
- LOOKUP: cam_pattern_o={1,tag_q}; sample cam_found_i and cam_match_i.
  - Found: go to RESP with hit=1, idx=match.
  - Not found: go to WALK.
- Hit latency: request accepted at edge N, resp_valid_o=1 after edge N+2.
- WALK:
  - walk_req_o=1, walk_tag_o=tag_q, held until walk_done_i.
  - On walk_done_i with walk_fault_i=1: go to RESP with fault=1, hit=0, idx=0. No CAM write; victim unchanged.
  - Otherwise go to FILL.
- FILL (1 cycle):
  - cam_we_o=1, cam_wraddr_o=victim, cam_pattern_o={1,tag_q}.
  - resp_idx := victim; victim := victim+1 mod DEPTH, wrapping DEPTH-1→0. Go to RESP with hit=0.
- RESP:
  - resp_* are held stable while resp_ready_i=0.
  - On resp_valid_o&resp_ready_i: clear resp_valid_o and go to IDLE.
- flush_i outside IDLE/FLUSH sets flush_pending. The current operation, including walk and fill, completes first.
- flush_i during FLUSH is ignored; no restart.
- cam_we_o is 0 and cam_pattern_o is {1,tag_q} in all states except FLUSH and FILL.
- Async reset mid-operation: all outputs go to 0 immediately and walk_req_o drops. On release, a full flush runs.
- walk_done_i outside WALK is ignored.

Decomposition:
- Package atc_pkg: state enum atc_state_e; PATTERN_W = TAG_W+1; PATTERN_VALID_BIT = TAG_W.
- No sub-module required. The victim pointer and flush counter are inline counters in one module.

Test Plan:
1. Release reset: cam_we_o=1 for 32 cycles, wraddr 0..31, pattern 0, flush_busy_o=1. req_ready_o=1 in cycle 33.
2. Lookup tag 0x123456 cold → walk_req_o=1 with walk_tag_o=0x123456; done after 5 cycles → one FILL write at idx 0, pattern 0x1123456; resp hit=0, idx=0. Repeat lookup → hit=1, idx=0 two cycles after accept, no walk.
3. 33 distinct tags filled → 33rd written at idx 0; lookup of first tag misses and walks again.
4. walk_done_i with walk_fault_i=1 → resp fault=1, no cam_we_o pulse; next fill still uses the previous victim index.
5. flush_i pulse during WALK → walk, fill and resp complete; then a 32-cycle FLUSH. A later lookup of the same tag misses; the next fill goes to idx 0.
6. Hold resp_ready_i=0 for 4 cycles → resp_* stable. Assert rst_ni=0 while in WALK → walk_req_o=0 the same cycle; a flush runs after release.

Source files
------------

// File: rtl/atc_pkg.sv
// rtl/atc_pkg.sv - shared types and widths for the ATC tag-CAM lookup sequencer.
package atc_pkg;

  localparam int TAG_W_DEF         = 24;
  localparam int DEPTH_DEF         = 32;
  localparam int PATTERN_W         = TAG_W_DEF + 1;
  localparam int PATTERN_VALID_BIT = TAG_W_DEF;

  typedef enum logic [2:0] {
    ST_FLUSH  = 3'd0,
    ST_IDLE   = 3'd1,
    ST_LOOKUP = 3'd2,
    ST_WALK   = 3'd3,
    ST_FILL   = 3'd4,
    ST_RESP   = 3'd5
  } atc_state_e;

endpackage

// File: rtl/atc_lookup_ctrl.sv
// rtl/atc_lookup_ctrl.sv - ATC tag-CAM sequencer: lookup, walk-on-miss, round-robin fill, flush.
module atc_lookup_ctrl
  import atc_pkg::*;
#(
  parameter  int TAG_W = TAG_W_DEF,
  parameter  int DEPTH = DEPTH_DEF,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [TAG_W-1:0] req_tag_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic             resp_hit_o,
  output logic             resp_fault_o,
  output logic [IDX_W-1:0] resp_idx_o,
  output logic             walk_req_o,
  output logic [TAG_W-1:0] walk_tag_o,
  input  logic             walk_done_i,
  input  logic             walk_fault_i,
  input  logic             flush_i,
  output logic             flush_busy_o,
  output logic [TAG_W:0]   cam_pattern_o,
  output logic             cam_we_o,
  output logic [IDX_W-1:0] cam_wraddr_o,
  input  logic             cam_found_i,
  input  logic [IDX_W-1:0] cam_match_i
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  atc_state_e       state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] victim_q, victim_d;
  logic             pend_q, pend_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             live_q, live_d;
  logic             rvalid_q, rvalid_d;
  logic             rhit_q, rhit_d;
  logic             rfault_q, rfault_d;
  logic [IDX_W-1:0] ridx_q, ridx_d;

  // live_q holds every output at 0 for the first cycle after reset release,
  // so the flush of entry 0 starts one edge after rst_ni rises.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    victim_d      = victim_q;
    pend_d        = pend_q;
    tag_d         = tag_q;
    live_d        = 1'b1;
    rvalid_d      = rvalid_q;
    rhit_d        = rhit_q;
    rfault_d      = rfault_q;
    ridx_d        = ridx_q;
    req_ready_o   = 1'b0;
    walk_req_o    = 1'b0;
    flush_busy_o  = 1'b0;
    cam_we_o      = 1'b0;
    cam_wraddr_o  = '0;
    cam_pattern_o = '0;
    if (live_q) begin
      cam_pattern_o = {1'b1, tag_q};
      case (state_q)
        ST_FLUSH: begin
          cam_we_o      = 1'b1;
          cam_wraddr_o  = cnt_q;
          cam_pattern_o = '0;
          flush_busy_o  = 1'b1;
          victim_d      = '0;
          pend_d        = 1'b0;
          cnt_d         = cnt_q + IDX_W'(1);
          if (cnt_q == LAST_IDX) state_d = ST_IDLE;
        end
        ST_IDLE: begin
          if (pend_q || flush_i) begin
            pend_d  = 1'b0;
            state_d = ST_FLUSH;
          end else begin
            req_ready_o = 1'b1;
            if (req_valid_i) begin
              tag_d   = req_tag_i;
              state_d = ST_LOOKUP;
            end
          end
        end
        ST_LOOKUP: begin
          pend_d = pend_q | flush_i;
          if (cam_found_i) begin
            rhit_d   = 1'b1;
            rfault_d = 1'b0;
            ridx_d   = cam_match_i;
            state_d  = ST_RESP;
          end else begin
            state_d = ST_WALK;
          end
        end
        ST_WALK: begin
          pend_d     = pend_q | flush_i;
          walk_req_o = 1'b1;
          if (walk_done_i) begin
            if (walk_fault_i) begin
              rhit_d   = 1'b0;
              rfault_d = 1'b1;
              ridx_d   = '0;
              state_d  = ST_RESP;
            end else begin
              state_d = ST_FILL;
            end
          end
        end
        ST_FILL: begin
          pend_d       = pend_q | flush_i;
          cam_we_o     = 1'b1;
          cam_wraddr_o = victim_q;
          rhit_d       = 1'b0;
          rfault_d     = 1'b0;
          ridx_d       = victim_q;
          victim_d     = victim_q + IDX_W'(1);
          state_d      = ST_RESP;
        end
        ST_RESP: begin
          // Response is registered: valid rises one cycle after entering RESP.
          pend_d   = pend_q | flush_i;
          rvalid_d = 1'b1;
          if (rvalid_q && resp_ready_i) begin
            rvalid_d = 1'b0;
            state_d  = ST_IDLE;
          end
        end
        default: state_d = ST_FLUSH;
      endcase
    end
  end

  assign walk_tag_o   = walk_req_o ? tag_q : '0;
  assign resp_valid_o = rvalid_q;
  assign resp_hit_o   = rhit_q;
  assign resp_fault_o = rfault_q;
  assign resp_idx_o   = ridx_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_FLUSH;
      cnt_q    <= '0;
      victim_q <= '0;
      pend_q   <= 1'b0;
      tag_q    <= '0;
      live_q   <= 1'b0;
      rvalid_q <= 1'b0;
      rhit_q   <= 1'b0;
      rfault_q <= 1'b0;
      ridx_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      victim_q <= victim_d;
      pend_q   <= pend_d;
      tag_q    <= tag_d;
      live_q   <= live_d;
      rvalid_q <= rvalid_d;
      rhit_q   <= rhit_d;
      rfault_q <= rfault_d;
      ridx_q   <= ridx_d;
    end
  end

endmodule

// File: tb/tb_atc_lookup_ctrl.sv
// tb/tb_atc_lookup_ctrl.sv - directed bench for atc_lookup_ctrl with a behavioural tag CAM.
module tb_atc_lookup_ctrl;

  localparam int TAG_W = 24;
  localparam int DEPTH = 32;
  localparam int IDX_W = 5;
  localparam int PAT_W = TAG_W + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_valid_i = 1'b0;
  logic             req_ready_o;
  logic [TAG_W-1:0] req_tag_i = '0;
  logic             resp_valid_o;
  logic             resp_ready_i = 1'b0;
  logic             resp_hit_o;
  logic             resp_fault_o;
  logic [IDX_W-1:0] resp_idx_o;
  logic             walk_req_o;
  logic [TAG_W-1:0] walk_tag_o;
  logic             walk_done_i = 1'b0;
  logic             walk_fault_i = 1'b0;
  logic             flush_i = 1'b0;
  logic             flush_busy_o;
  logic [PAT_W-1:0] cam_pattern_o;
  logic             cam_we_o;
  logic [IDX_W-1:0] cam_wraddr_o;
  logic             cam_found_i;
  logic [IDX_W-1:0] cam_match_i;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  atc_lookup_ctrl #(.TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_tag_i(req_tag_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_hit_o(resp_hit_o),
    .resp_fault_o(resp_fault_o), .resp_idx_o(resp_idx_o),
    .walk_req_o(walk_req_o), .walk_tag_o(walk_tag_o), .walk_done_i(walk_done_i),
    .walk_fault_i(walk_fault_i), .flush_i(flush_i), .flush_busy_o(flush_busy_o),
    .cam_pattern_o(cam_pattern_o), .cam_we_o(cam_we_o), .cam_wraddr_o(cam_wraddr_o),
    .cam_found_i(cam_found_i), .cam_match_i(cam_match_i)
  );

  logic [PAT_W-1:0] cam_mem [DEPTH];

  always @(posedge clk) begin
    if (cam_we_o) cam_mem[cam_wraddr_o] <= cam_pattern_o;
  end

  always_comb begin
    cam_found_i = 1'b0;
    cam_match_i = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (cam_pattern_o[TAG_W] && cam_mem[i] == cam_pattern_o) begin
        cam_found_i = 1'b1;
        cam_match_i = IDX_W'(i);
      end
    end
  end

  bit               obs_timeout, obs_walked, obs_stable, obs_valid_after;
  logic [TAG_W-1:0] obs_walk_tag;
  int               obs_we_cnt, obs_lat;
  logic [IDX_W-1:0] obs_we_addr, obs_idx;
  logic [PAT_W-1:0] obs_we_pat;
  logic             obs_hit, obs_fault;

  task automatic do_lookup(input logic [TAG_W-1:0] tag, input int walk_delay,
                           input bit fault, input bit flush_in_walk, input int hold);
    int guard;
    int wcnt;
    obs_timeout = 0; obs_walked = 0; obs_stable = 1; obs_valid_after = 0;
    obs_walk_tag = '0; obs_we_cnt = 0; obs_we_addr = '0; obs_we_pat = '0;
    obs_hit = 0; obs_fault = 0; obs_idx = '0; obs_lat = 0;
    guard = 0;
    while (!req_ready_o && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready_o) begin
      obs_timeout = 1;
      return;
    end
    req_valid_i = 1'b1;
    req_tag_i   = tag;
    @(negedge clk);
    req_valid_i = 1'b0;
    wcnt  = 0;
    guard = 0;
    while (!resp_valid_o && guard < 300) begin
      if (walk_done_i) begin
        walk_done_i  = 1'b0;
        walk_fault_i = 1'b0;
      end
      flush_i = 1'b0;
      if (walk_req_o) begin
        if (!obs_walked && flush_in_walk) flush_i = 1'b1;
        obs_walked   = 1;
        obs_walk_tag = walk_tag_o;
        wcnt++;
        if (wcnt == walk_delay) begin
          walk_done_i  = 1'b1;
          walk_fault_i = fault;
        end
      end
      if (cam_we_o) begin
        obs_we_cnt++;
        obs_we_addr = cam_wraddr_o;
        obs_we_pat  = cam_pattern_o;
      end
      @(negedge clk);
      obs_lat++;
      guard++;
    end
    walk_done_i  = 1'b0;
    walk_fault_i = 1'b0;
    flush_i      = 1'b0;
    if (!resp_valid_o) begin
      obs_timeout = 1;
      return;
    end
    obs_hit   = resp_hit_o;
    obs_fault = resp_fault_o;
    obs_idx   = resp_idx_o;
    repeat (hold) begin
      @(negedge clk);
      if (resp_valid_o !== 1'b1 || resp_hit_o !== obs_hit || resp_fault_o !== obs_fault ||
          resp_idx_o !== obs_idx) obs_stable = 0;
    end
    resp_ready_i = 1'b1;
    @(negedge clk);
    resp_ready_i    = 1'b0;
    obs_valid_after = resp_valid_o;
  endtask

  task automatic count_flush(output int n);
    n = 0;
    for (int g = 0; g < 100; g++) begin
      @(negedge clk);
      if (flush_busy_o && cam_we_o && cam_pattern_o == '0) n++;
      else if (n > 0) break;
    end
  endtask

  task automatic test_reset;
    bit ok;
    repeat (2) @(negedge clk);
    total++;
    if ({req_ready_o, resp_valid_o, walk_req_o, flush_busy_o, cam_we_o} !== 5'b0 ||
        cam_pattern_o !== '0 || cam_wraddr_o !== '0 || walk_tag_o !== '0 || resp_idx_o !== '0)
      $display("FAIL reset_outputs: ready=%b valid=%b walk=%b busy=%b we=%b pat=%h required all 0",
               req_ready_o, resp_valid_o, walk_req_o, flush_busy_o, cam_we_o, cam_pattern_o);
    else passed++;
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      ok = (cam_we_o === 1'b1) && (cam_wraddr_o === IDX_W'(i)) &&
           (cam_pattern_o === '0) && (flush_busy_o === 1'b1) && (req_ready_o === 1'b0);
      total++;
      if (!ok) $display("FAIL flush_cycle_%0d: we=%b addr=%0d pat=%h busy=%b required we=1 addr=%0d pat=0 busy=1",
                        i, cam_we_o, cam_wraddr_o, cam_pattern_o, flush_busy_o, i);
      else passed++;
    end
    @(negedge clk);
    total++;
    if (req_ready_o !== 1'b1 || cam_we_o !== 1'b0 || flush_busy_o !== 1'b0)
      $display("FAIL ready_after_flush: ready=%b we=%b busy=%b required 1 0 0",
               req_ready_o, cam_we_o, flush_busy_o);
    else passed++;
  endtask

  task automatic test_miss_then_hit;
    do_lookup(24'h123456, 5, 1'b0, 1'b0, 0);
    total++;
    if (obs_timeout || !obs_walked || obs_walk_tag !== 24'h123456)
      $display("FAIL cold_walk: timeout=%b walked=%b tag=%h required 0 1 123456",
               obs_timeout, obs_walked, obs_walk_tag);
    else passed++;
    total++;
    if (obs_we_cnt != 1 || obs_we_addr !== 5'd0 || obs_we_pat !== 25'h1123456)
      $display("FAIL cold_fill: writes=%0d addr=%0d pat=%h required 1 0 1123456",
               obs_we_cnt, obs_we_addr, obs_we_pat);
    else passed++;
    total++;
    if (obs_hit !== 1'b0 || obs_fault !== 1'b0 || obs_idx !== 5'd0 || obs_valid_after !== 1'b0)
      $display("FAIL cold_resp: hit=%b fault=%b idx=%0d valid_after=%b required 0 0 0 0",
               obs_hit, obs_fault, obs_idx, obs_valid_after);
    else passed++;
    do_lookup(24'h123456, 5, 1'b0, 1'b0, 0);
    total++;
    if (obs_timeout || obs_walked || obs_we_cnt != 0 || obs_hit !== 1'b1 || obs_idx !== 5'd0)
      $display("FAIL warm_hit: timeout=%b walked=%b writes=%0d hit=%b idx=%0d required 0 0 0 1 0",
               obs_timeout, obs_walked, obs_we_cnt, obs_hit, obs_idx);
    else passed++;
    total++;
    if (obs_lat != 2) $display("FAIL hit_latency: edges=%0d required 2", obs_lat);
    else passed++;
  endtask

  task automatic test_victim_wrap;
    int bad;
    bad = 0;
    for (int i = 1; i <= 32; i++) begin
      do_lookup(24'h200000 + 24'(i), 2, 1'b0, 1'b0, 0);
      if (obs_timeout || obs_hit !== 1'b0 || obs_idx !== IDX_W'(i % DEPTH) || obs_we_addr !== IDX_W'(i % DEPTH))
        bad++;
    end
    total++;
    if (bad != 0) $display("FAIL fill_sequence: bad_fills=%0d required 0", bad);
    else passed++;
    total++;
    if (obs_we_addr !== 5'd0 || obs_idx !== 5'd0)
      $display("FAIL wrap_slot: addr=%0d idx=%0d required 0 0", obs_we_addr, obs_idx);
    else passed++;
    do_lookup(24'h123456, 2, 1'b0, 1'b0, 0);
    total++;
    if (obs_timeout || !obs_walked || obs_hit !== 1'b0 || obs_idx !== 5'd1)
      $display("FAIL evicted_rewalk: walked=%b hit=%b idx=%0d required 1 0 1",
               obs_walked, obs_hit, obs_idx);
    else passed++;
  endtask

  task automatic test_walk_fault;
    do_lookup(24'hABCDEF, 3, 1'b1, 1'b0, 0);
    total++;
    if (obs_timeout || obs_fault !== 1'b1 || obs_hit !== 1'b0 || obs_idx !== 5'd0 || obs_we_cnt != 0)
      $display("FAIL fault_resp: fault=%b hit=%b idx=%0d writes=%0d required 1 0 0 0",
               obs_fault, obs_hit, obs_idx, obs_we_cnt);
    else passed++;
    do_lookup(24'hABCDEF, 1, 1'b0, 1'b0, 0);
    total++;
    if (obs_timeout || obs_fault !== 1'b0 || obs_we_addr !== 5'd2 || obs_idx !== 5'd2)
      $display("FAIL fill_after_fault: fault=%b addr=%0d idx=%0d required 0 2 2",
               obs_fault, obs_we_addr, obs_idx);
    else passed++;
  endtask

  task automatic test_flush_pending;
    int n;
    do_lookup(24'h555555, 4, 1'b0, 1'b1, 0);
    total++;
    if (obs_timeout || obs_we_cnt != 1 || obs_we_addr !== 5'd3 || obs_idx !== 5'd3 || obs_hit !== 1'b0)
      $display("FAIL pending_op_completes: writes=%0d addr=%0d idx=%0d hit=%b required 1 3 3 0",
               obs_we_cnt, obs_we_addr, obs_idx, obs_hit);
    else passed++;
    total++;
    if (req_ready_o !== 1'b0) $display("FAIL pending_blocks_ready: ready=%b required 0", req_ready_o);
    else passed++;
    count_flush(n);
    total++;
    if (n != DEPTH) $display("FAIL pending_flush_len: cycles=%0d required %0d", n, DEPTH);
    else passed++;
    do_lookup(24'h555555, 2, 1'b0, 1'b0, 0);
    total++;
    if (obs_timeout || !obs_walked || obs_we_addr !== 5'd0 || obs_idx !== 5'd0)
      $display("FAIL post_flush_miss: walked=%b addr=%0d idx=%0d required 1 0 0",
               obs_walked, obs_we_addr, obs_idx);
    else passed++;
  endtask

  task automatic test_resp_hold;
    do_lookup(24'h555555, 2, 1'b0, 1'b0, 4);
    total++;
    if (obs_timeout || !obs_stable || obs_hit !== 1'b1 || obs_idx !== 5'd0 || obs_valid_after !== 1'b0)
      $display("FAIL resp_hold: stable=%b hit=%b idx=%0d valid_after=%b required 1 1 0 0",
               obs_stable, obs_hit, obs_idx, obs_valid_after);
    else passed++;
  endtask

  task automatic test_walk_done_ignored;
    @(negedge clk);
    walk_done_i = 1'b1;
    @(negedge clk);
    walk_done_i = 1'b0;
    @(negedge clk);
    total++;
    if (req_ready_o !== 1'b1 || resp_valid_o !== 1'b0 || cam_we_o !== 1'b0 || walk_req_o !== 1'b0)
      $display("FAIL stray_walk_done: ready=%b valid=%b we=%b walk=%b required 1 0 0 0",
               req_ready_o, resp_valid_o, cam_we_o, walk_req_o);
    else passed++;
  endtask

  task automatic test_reset_mid_walk;
    int guard;
    int n;
    req_valid_i = 1'b1;
    req_tag_i   = 24'h777777;
    @(negedge clk);
    req_valid_i = 1'b0;
    guard = 0;
    while (!walk_req_o && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    total++;
    if (walk_req_o !== 1'b1 || walk_tag_o !== 24'h777777)
      $display("FAIL walk_before_reset: walk=%b tag=%h required 1 777777", walk_req_o, walk_tag_o);
    else passed++;
    rst_n = 1'b0;
    #1;
    total++;
    if (walk_req_o !== 1'b0 || cam_we_o !== 1'b0 || req_ready_o !== 1'b0 ||
        resp_valid_o !== 1'b0 || flush_busy_o !== 1'b0)
      $display("FAIL async_reset_outputs: walk=%b we=%b ready=%b valid=%b busy=%b required all 0",
               walk_req_o, cam_we_o, req_ready_o, resp_valid_o, flush_busy_o);
    else passed++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    count_flush(n);
    total++;
    if (n != DEPTH) $display("FAIL reset_flush_len: cycles=%0d required %0d", n, DEPTH);
    else passed++;
    do_lookup(24'h123456, 2, 1'b0, 1'b0, 0);
    total++;
    if (obs_timeout || !obs_walked || obs_hit !== 1'b0 || obs_idx !== 5'd0)
      $display("FAIL after_reset_fill: walked=%b hit=%b idx=%0d required 1 0 0",
               obs_walked, obs_hit, obs_idx);
    else passed++;
  endtask

  initial begin
    test_reset;
    test_miss_then_hit;
    test_victim_wrap;
    test_walk_fault;
    test_flush_pending;
    test_resp_hold;
    test_walk_done_ignored;
    test_reset_mid_walk;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
